// File: rtl/control_unit.sv
// control_unit: fetch/decode/execute FSM driving every ALUSystem control input
//
// Ports:
//   clk, rst          system clock (rising edge); asynchronous active-high reset to S_INIT
//   IR_Out[15:0]      instruction register: [15:12] opcode, [11:10] Rd, [9:8] Rs, [7:0] imm/addr
//   ALU_Flags[3:0]    {O,N,C,Z}; only Z is consulted (BEQ)
//   RF_*, ARF_*, IR_* register-file, address-register-file and IR controls
//   ALU_FunSel        ALU operation
//   Mem_WR, Mem_CS    memory strobes (Mem_CS active low)
//   MuxASel/BSel/CSel datapath mux selects
//   Halted            high while in S_HALT
//   State             current FSM state (debug)
module control_unit #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] IR_Out,
    input  logic [3:0]  ALU_Flags,
    output logic [2:0]  RF_O1Sel,
    output logic [2:0]  RF_O2Sel,
    output logic [1:0]  RF_FunSel,
    output logic [3:0]  RF_RSel,
    output logic [3:0]  RF_TSel,
    output logic [3:0]  ALU_FunSel,
    output logic [1:0]  ARF_OutASel,
    output logic [1:0]  ARF_OutBSel,
    output logic [1:0]  ARF_FunSel,
    output logic [3:0]  ARF_RSel,
    output logic        IR_LH,
    output logic        IR_Enable,
    output logic [1:0]  IR_Funsel,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxCSel,
    output logic        Halted,
    output logic [3:0]  State
);
    typedef enum logic [3:0] {
        S_INIT, S_F0, S_F1, S_F2, S_F3, S_DEC,
        S_E0, S_E1, S_E2, S_E3, S_E4, S_HALT
    } state_t;
    state_t state, nxt;
    logic [3:0] op;
    logic [1:0] rd, rs;
    logic is_ldi, is_alu, is_jmp, exec;
    logic unused_bits;
    assign op     = IR_Out[15:12];
    assign rd     = IR_Out[11:10];
    assign rs     = IR_Out[9:8];
    assign is_ldi = op == 4'h1;
    assign is_alu = op == 4'h2 || op == 4'h3;
    // BEQ only reaches the execute states when taken, so it shares JMP's path
    assign is_jmp = op == 4'h4 || op == 4'h6;
    assign exec   = state inside {[S_E0:S_E4]};
    assign unused_bits = ^{ALU_Flags[3:1], IR_Out[7:0]};
    assign RF_TSel     = 4'b0000;
    assign ARF_OutASel = 2'b00;
    assign ARF_OutBSel = 2'b11;
    assign Mem_WR      = 1'b0;
    assign MuxCSel     = 1'b0;
    assign Halted      = state == S_HALT;
    assign State       = state;
    // Operand routing is held stable across the whole execute phase so the
    // registered RF/mux/ALU chain sees constant selects while it fills.
    assign RF_O1Sel   = exec ? {1'b1, rd} : 3'b000;
    assign RF_O2Sel   = exec ? {1'b1, rs} : 3'b000;
    assign MuxASel    = exec && is_ldi ? 2'b10 : 2'b00;
    assign MuxBSel    = exec && is_jmp ? 2'b10 : 2'b00;
    assign ALU_FunSel = !exec ? 4'b0000 : op == 4'h2 ? 4'b0100 : op == 4'h3 ? 4'b0101 : 4'b0000;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= S_INIT;
        else     state <= nxt;
    always_comb begin
        nxt        = state;
        RF_FunSel  = 2'b00;
        RF_RSel    = 4'b0000;
        ARF_FunSel = 2'b00;
        ARF_RSel   = 4'b0000;
        IR_LH      = 1'b0;
        IR_Enable  = 1'b0;
        IR_Funsel  = 2'b00;
        Mem_CS     = 1'b1;
        case (state)
            S_INIT: begin
                ARF_RSel  = 4'b1000;
                IR_Enable = 1'b1;
                nxt       = S_F0;
            end
            S_F0: nxt = S_F1;
            S_F1, S_F3: begin
                Mem_CS     = 1'b0;
                IR_Enable  = 1'b1;
                IR_Funsel  = 2'b01;
                IR_LH      = state == S_F3;
                ARF_FunSel = 2'b10;
                ARF_RSel   = 4'b1000;
                nxt        = state == S_F1 ? S_F2 : S_DEC;
            end
            S_F2: nxt = S_F3;
            S_DEC: nxt = op == 4'h0                    ? S_F0 :
                         (is_ldi || is_alu || op == 4'h4) ? S_E0 :
                         op == 4'h6                    ? (ALU_Flags[0] ? S_E0 : S_F0) :
                         op == 4'h5                    ? S_HALT :
                         HALT_ON_ILLEGAL               ? S_HALT : S_F0;
            S_E0: nxt = S_E1;
            S_E1: begin
                RF_FunSel  = is_ldi ? 2'b01 : 2'b00;
                RF_RSel    = is_ldi ? 4'b1000 >> rd : 4'b0000;
                ARF_FunSel = is_jmp ? 2'b01 : 2'b00;
                ARF_RSel   = is_jmp ? 4'b1000 : 4'b0000;
                nxt        = is_alu ? S_E2 : S_F0;
            end
            S_E2: nxt = S_E3;
            S_E3: nxt = S_E4;
            S_E4: begin
                RF_FunSel = 2'b01;
                RF_RSel   = 4'b1000 >> rd;
                nxt       = S_F0;
            end
            S_HALT: nxt = S_HALT;
            default: nxt = S_INIT;
        endcase
    end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed bench for control_unit with a small functional datapath model
module tb_control_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [3:0] flags = 4'h0;
    always #5 clk = ~clk;

    logic [2:0] RF_O1Sel, RF_O2Sel;
    logic [1:0] RF_FunSel, ARF_OutASel, ARF_OutBSel, ARF_FunSel, IR_Funsel, MuxASel, MuxBSel;
    logic [3:0] RF_RSel, RF_TSel, ALU_FunSel, ARF_RSel, State;
    logic IR_LH, IR_Enable, Mem_WR, Mem_CS, MuxCSel, Halted;

    logic [2:0] z_O1Sel, z_O2Sel;
    logic [1:0] z_RFFun, z_OutA, z_OutB, z_ARFFun, z_IRFun, z_MuxA, z_MuxB;
    logic [3:0] z_RSel, z_TSel, z_ALUFun, z_ARSel, z_State;
    logic z_LH, z_IREn, z_WR, z_CS, z_MuxC, z_Halted;

    // datapath model: memory, PC, IR and R1..R4 driven by the control outputs
    logic [7:0]  mem [256];
    logic [7:0]  pc;
    logic [15:0] ir;
    logic [7:0]  rf [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0]  a, b, alu, bus;
    assign a   = rf[RF_O1Sel[1:0]];
    assign b   = rf[RF_O2Sel[1:0]];
    assign alu = !(RF_O1Sel[2] && RF_O2Sel[2]) ? 8'hxx :
                 ALU_FunSel == 4'b0100 ? a + b :
                 ALU_FunSel == 4'b0101 ? a - b : 8'hxx;
    assign bus = (Mem_CS || ARF_OutBSel != 2'b11) ? 8'hxx : mem[pc];

    always @(posedge clk) begin
        if (ARF_RSel[3])
            pc <= ARF_FunSel == 2'b00 ? 8'h00 :
                  ARF_FunSel == 2'b10 ? pc + 8'h01 :
                  (ARF_FunSel == 2'b01 && MuxBSel == 2'b10) ? ir[7:0] : 8'hxx;
        if (IR_Enable)
            ir <= IR_Funsel == 2'b00 ? 16'h0000 :
                  IR_Funsel == 2'b01 ? (IR_LH ? {ir[15:8], bus} : {bus, ir[7:0]}) : 16'hxxxx;
        for (int k = 0; k < 4; k++)
            if (RF_RSel[3-k])
                rf[k] <= RF_FunSel != 2'b01 ? 8'hxx :
                         MuxASel == 2'b10 ? ir[7:0] :
                         MuxASel == 2'b00 ? alu : 8'hxx;
    end

    control_unit dut (
        .clk(clk), .rst(rst), .IR_Out(ir), .ALU_Flags(flags),
        .RF_O1Sel(RF_O1Sel), .RF_O2Sel(RF_O2Sel), .RF_FunSel(RF_FunSel), .RF_RSel(RF_RSel),
        .RF_TSel(RF_TSel), .ALU_FunSel(ALU_FunSel), .ARF_OutASel(ARF_OutASel),
        .ARF_OutBSel(ARF_OutBSel), .ARF_FunSel(ARF_FunSel), .ARF_RSel(ARF_RSel),
        .IR_LH(IR_LH), .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel), .Mem_WR(Mem_WR),
        .Mem_CS(Mem_CS), .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel),
        .Halted(Halted), .State(State)
    );

    control_unit #(.HALT_ON_ILLEGAL(1'b0)) dut0 (
        .clk(clk), .rst(rst), .IR_Out(16'hF000), .ALU_Flags(4'h0),
        .RF_O1Sel(z_O1Sel), .RF_O2Sel(z_O2Sel), .RF_FunSel(z_RFFun), .RF_RSel(z_RSel),
        .RF_TSel(z_TSel), .ALU_FunSel(z_ALUFun), .ARF_OutASel(z_OutA),
        .ARF_OutBSel(z_OutB), .ARF_FunSel(z_ARFFun), .ARF_RSel(z_ARSel),
        .IR_LH(z_LH), .IR_Enable(z_IREn), .IR_Funsel(z_IRFun), .Mem_WR(z_WR),
        .Mem_CS(z_CS), .MuxASel(z_MuxA), .MuxBSel(z_MuxB), .MuxCSel(z_MuxC),
        .Halted(z_Halted), .State(z_State)
    );

    int total = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // asynchronous reset pulse, released mid-cycle; returns sampled in S_F0
    task automatic do_reset();
        rst = 1'b1;
        #2;
        chk("rst_state", State, 4'd0);
        chk("rst_cs", Mem_CS, 1'b1);
        chk("rst_init_out", {IR_Enable, IR_Funsel, ARF_RSel, ARF_FunSel}, {1'b1, 2'b00, 4'b1000, 2'b00});
        @(negedge clk);
        rst = 1'b0;
        tick(1);
        chk("f0_state", State, 4'd1);
        chk("f0_pc", pc, 8'h00);
        chk("f0_ir", ir, 16'h0000);
    endtask

    initial begin
        foreach (mem[i]) mem[i] = 8'h00;
        #12;
        // LDI R1,0x2A
        mem[0] = 8'h10; mem[1] = 8'h2A;
        do_reset();
        chk("f0_cs", Mem_CS, 1'b1);
        tick(1);
        chk("f1_cs", Mem_CS, 1'b0);
        tick(6);
        chk("ldi_r1", rf[0], 8'h2A);
        chk("ldi_others", {rf[1], rf[2], rf[3]}, 24'h223344);
        chk("ldi_pc", pc, 8'h02);
        chk("ldi_state", State, 4'd1);
        // LDI R1,5; LDI R2,3; ADD R1,R2
        mem[0] = 8'h10; mem[1] = 8'h05; mem[2] = 8'h14; mem[3] = 8'h03; mem[4] = 8'h21; mem[5] = 8'h00;
        do_reset();
        tick(14);
        chk("ld2_r1", rf[0], 8'h05);
        chk("ld2_r2", rf[1], 8'h03);
        tick(9);
        chk("add_e4_state", State, 4'd10);
        chk("add_e4_sel", {RF_RSel, RF_FunSel, RF_O1Sel, RF_O2Sel, ALU_FunSel},
            {4'b1000, 2'b01, 3'b100, 3'b101, 4'b0100});
        tick(1);
        chk("add_r1", rf[0], 8'h08);
        chk("add_r2", rf[1], 8'h03);
        chk("add_pc", pc, 8'h06);
        chk("add_state", State, 4'd1);
        // same setup, SUB R1,R2
        mem[4] = 8'h31;
        do_reset();
        tick(24);
        chk("sub_r1", rf[0], 8'h02);
        chk("sub_r2", rf[1], 8'h03);
        // JMP 0x40; LDI R1,0x77; BEQ (Z=0); BEQ 0x20 (Z=1); HLT
        mem[0] = 8'h40; mem[1] = 8'h40;
        mem[8'h40] = 8'h10; mem[8'h41] = 8'h77;
        mem[8'h42] = 8'h60; mem[8'h43] = 8'h10;
        mem[8'h44] = 8'h60; mem[8'h45] = 8'h20;
        mem[8'h20] = 8'h50; mem[8'h21] = 8'h00;
        do_reset();
        tick(6);
        chk("jmp_e1_state", State, 4'd7);
        chk("jmp_e1_sel", {ARF_RSel, ARF_FunSel, MuxBSel}, {4'b1000, 2'b01, 2'b10});
        tick(1);
        chk("jmp_pc", pc, 8'h40);
        chk("jmp_state", State, 4'd1);
        tick(7);
        chk("jmp_fetch_r1", rf[0], 8'h77);
        chk("jmp_fetch_pc", pc, 8'h42);
        flags = 4'h0;
        tick(5);
        chk("beq_nt_pc", pc, 8'h44);
        chk("beq_nt_state", State, 4'd1);
        flags = 4'h1;
        tick(7);
        chk("beq_t_pc", pc, 8'h20);
        flags = 4'h0;
        tick(5);
        chk("hlt_halted", Halted, 1'b1);
        chk("hlt_state", State, 4'd11);
        for (int i = 0; i < 100; i++) begin
            tick(1);
            chk("hlt_hold_state", State, 4'd11);
            chk("hlt_hold_en", {RF_RSel, ARF_RSel, IR_Enable}, 9'd0);
        end
        do_reset();
        tick(2);
        chk("restart_ir_hi", ir[15:8], 8'h40);
        chk("restart_pc", pc, 8'h01);
        // illegal opcode 0xF
        mem[0] = 8'hF0; mem[1] = 8'h00;
        do_reset();
        chk("ill0_f0", z_State, 4'd1);
        tick(4);
        chk("ill_dec", State, 4'd5);
        chk("ill0_dec", z_State, 4'd5);
        tick(1);
        chk("ill_halted", {Halted, State}, {1'b1, 4'd11});
        chk("ill0_nop", {z_Halted, z_State}, {1'b0, 4'd1});
        // reset during ADD's S_E2 leaves Rd alone
        mem[0] = 8'h10; mem[1] = 8'h05; mem[2] = 8'h14; mem[3] = 8'h03; mem[4] = 8'h21; mem[5] = 8'h00;
        do_reset();
        tick(21);
        chk("abort_e2_state", State, 4'd8);
        rst = 1'b1;
        #1;
        chk("abort_rst_state", State, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        tick(5);
        chk("abort_r1", rf[0], 8'h05);
        chk("abort_r2", rf[1], 8'h03);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
